sub_bytes_serial: RTL

SUB_BYTES_SERIAL -- requirements
Module: sub_bytes_serial

---
 rtl/sub_bytes_serial_pkg.sv | 34 +++
 rtl/sub_bytes_serial_sbox.sv | 11 +
 rtl/sub_bytes_serial.sv | 107 ++++++++++
 3 files changed

// File: rtl/sub_bytes_serial_pkg.sv
// Shared AES definitions: state geometry, the FIPS-197 S-box table and the
// SubBytes control state type. Also imported by the key-expansion logic.
package sub_bytes_serial_pkg;

    localparam int STATE_W   = 128;
    localparam int NUM_BYTES = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } sbs_state_e;

    // Forward S-box, indexed by the input byte value.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/sub_bytes_serial_sbox.sv
// One combinational S-box lane: table lookup only, nothing else.
module sub_bytes_serial_sbox
    import sub_bytes_serial_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    assign byte_o = SBOX[byte_i];

endmodule

// File: rtl/sub_bytes_serial.sv
// Iterative AES SubBytes: substitutes BYTES_PER_CYCLE bytes of the held state per
// cycle. Handshake: a word moves when valid and ready are both high on a rising edge.
module sub_bytes_serial
    import sub_bytes_serial_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [0:STATE_W-1]   in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [0:STATE_W-1]   out,
    output sbs_state_e           dbg_state_o
);

    localparam int         LANES    = BYTES_PER_CYCLE;
    localparam logic [3:0] CNT_STEP = 4'(LANES);
    localparam logic [3:0] LAST_CNT = 4'(NUM_BYTES - LANES);

    sbs_state_e         state_q;
    logic [3:0]         cnt_q;
    logic [0:STATE_W-1] data_q;
    logic [0:STATE_W-1] data_d;
    logic               in_ready_q;
    logic               out_valid_q;

    logic [7:0] lane_in  [LANES];
    logic [7:0] lane_out [LANES];

    // cnt_q is the index of the first byte handled in the current BUSY cycle.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        if (LANES < NUM_BYTES) begin : g_mux
            logic [6:0] bit_base;
            assign bit_base   = {cnt_q + 4'(l), 3'b000};
            assign lane_in[l] = data_q[bit_base +: 8];
        end else begin : g_direct
            assign lane_in[l] = data_q[8*l +: 8];
        end

        sub_bytes_serial_sbox u_sbox (
            .byte_i (lane_in[l]),
            .byte_o (lane_out[l])
        );
    end

    always_comb begin
        logic [6:0] wr_base;
        data_d  = data_q;
        wr_base = '0;
        for (int l = 0; l < LANES; l++) begin
            wr_base = {cnt_q + 4'(l), 3'b000};
            data_d[wr_base +: 8] = lane_out[l];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_q     <= in;
                        cnt_q      <= '0;
                        state_q    <= ST_BUSY;
                        in_ready_q <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    data_q <= data_d;
                    // 4-bit byte counter wraps to 0 after the last group.
                    cnt_q  <= cnt_q + CNT_STEP;
                    if (cnt_q == LAST_CNT) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out         = data_q;
    assign dbg_state_o = state_q;

endmodule
